// File: rtl/i2s_pkg.sv
// Shared I2S definitions used by both the receiver and the transmitter:
// default geometry, the receiver sync state and a counter-width helper.
package i2s_pkg;

  localparam int DATA_W_DEF   = 24;
  localparam int SLOT_W_DEF   = 32;
  localparam int SCLK_DIV_DEF = 8;

  typedef enum logic [0:0] {
    ST_SYNC = 1'b0,
    ST_RUN  = 1'b1
  } rx_state_e;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/i2s_clk_gen.sv
// I2S master clock generation: mclk, sclk and lrck plus the divider/bit
// counters, exporting the mid-sclk-high sample strobe and the frame-end strobe.
module i2s_clk_gen
  import i2s_pkg::*;
#(
  parameter int SLOT_W   = SLOT_W_DEF,
  parameter int SCLK_DIV = SCLK_DIV_DEF
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  output logic                          mclk_o,
  output logic                          sclk_o,
  output logic                          lrck_o,
  output logic [cnt_w(2*SLOT_W)-1:0]    bit_cnt_o,
  output logic                          sample_stb_o,
  output logic                          frame_end_o
);
  localparam int DIV_W = cnt_w(2*SCLK_DIV);
  localparam int BIT_W = cnt_w(2*SLOT_W);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(2*SCLK_DIV-1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(SCLK_DIV);
  localparam logic [DIV_W-1:0] DIV_SMP  = DIV_W'(3*SCLK_DIV/2);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2*SLOT_W-1);
  localparam logic [BIT_W-1:0] BIT_HALF = BIT_W'(SLOT_W);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             mclk_q, sclk_q, lrck_q;
  logic             div_wrap_s;

  // bit_cnt only moves on the sclk falling edge, so lrck follows it there
  always_comb begin
    div_wrap_s = (div_cnt_q == DIV_LAST);
    div_cnt_d  = div_wrap_s ? '0 : div_cnt_q + DIV_W'(1);
    if (div_wrap_s) begin
      bit_cnt_d = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + BIT_W'(1);
    end else begin
      bit_cnt_d = bit_cnt_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      div_cnt_q <= '0;
      bit_cnt_q <= '0;
      mclk_q    <= 1'b0;
      sclk_q    <= 1'b0;
      lrck_q    <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      mclk_q    <= ~mclk_q;
      sclk_q    <= (div_cnt_d >= DIV_HALF);
      lrck_q    <= (bit_cnt_d >= BIT_HALF);
    end
  end

  assign mclk_o       = mclk_q;
  assign sclk_o       = sclk_q;
  assign lrck_o       = lrck_q;
  assign bit_cnt_o    = bit_cnt_q;
  assign sample_stb_o = (div_cnt_q == DIV_SMP);
  assign frame_end_o  = div_wrap_s && (bit_cnt_q == BIT_LAST);

endmodule

// File: rtl/i2s_rx.sv
// I2S receiver (clock master): deserialises left/right samples from sdin and
// publishes complete stereo pairs through a valid/ready hand-off with overrun.
module i2s_rx
  import i2s_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int SLOT_W   = SLOT_W_DEF,
  parameter int SCLK_DIV = SCLK_DIV_DEF
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mclk,
  output logic              sclk,
  output logic              lrck,
  input  logic              sdin,
  output logic [DATA_W-1:0] left_data,
  output logic [DATA_W-1:0] right_data,
  output logic              sample_valid,
  input  logic              sample_ready,
  output logic              overrun
);
  localparam int BIT_W = cnt_w(2*SLOT_W);
  localparam logic [BIT_W-1:0] SLOT_BASE = BIT_W'(SLOT_W);
  localparam logic [BIT_W-1:0] FIRST_BIT = BIT_W'(1);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_W);

  logic              sample_stb_s, frame_end_s;
  logic [BIT_W-1:0]  bit_cnt_s, slot_idx_s;
  logic              right_slot_s, capture_s, publish_s;
  rx_state_e         state_q, state_d;
  logic              sdin_q;
  logic [DATA_W-1:0] left_sh_q, left_sh_d, right_sh_q, right_sh_d;
  logic [DATA_W-1:0] left_q, left_d, right_q, right_d;
  logic              valid_q, valid_d, ovr_q, ovr_d;

  i2s_clk_gen #(
    .SLOT_W  (SLOT_W),
    .SCLK_DIV(SCLK_DIV)
  ) u_clk_gen (
    .clk_i       (clk),
    .reset_i     (reset),
    .mclk_o      (mclk),
    .sclk_o      (sclk),
    .lrck_o      (lrck),
    .bit_cnt_o   (bit_cnt_s),
    .sample_stb_o(sample_stb_s),
    .frame_end_o (frame_end_s)
  );

  // Slot bit 0 is the I2S delay bit; only bits 1..DATA_W carry sample data
  always_comb begin
    right_slot_s = (bit_cnt_s >= SLOT_BASE);
    slot_idx_s   = right_slot_s ? (bit_cnt_s - SLOT_BASE) : bit_cnt_s;
    capture_s    = sample_stb_s && (slot_idx_s >= FIRST_BIT) && (slot_idx_s <= LAST_BIT);
  end

  always_comb begin
    left_sh_d  = left_sh_q;
    right_sh_d = right_sh_q;
    if (capture_s && !right_slot_s) begin
      left_sh_d = {left_sh_q[DATA_W-2:0], sdin_q};
    end else if (capture_s) begin
      right_sh_d = {right_sh_q[DATA_W-2:0], sdin_q};
    end else begin
      left_sh_d  = left_sh_q;
      right_sh_d = right_sh_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_SYNC;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    case (state_q)
      ST_SYNC: state_d = frame_end_s ? ST_RUN : ST_SYNC;
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_SYNC;
    endcase
  end

  // The first frame after reset may be partial, so it is never published
  always_comb begin
    case (state_q)
      ST_RUN:  publish_s = frame_end_s;
      ST_SYNC: publish_s = 1'b0;
      default: publish_s = 1'b0;
    endcase
  end

  always_comb begin
    left_d  = left_q;
    right_d = right_q;
    valid_d = valid_q;
    ovr_d   = 1'b0;
    if (publish_s && (!valid_q || sample_ready)) begin
      left_d  = left_sh_q;
      right_d = right_sh_q;
      valid_d = 1'b1;
    end else begin
      ovr_d = publish_s;
      if (sample_ready) begin
        valid_d = 1'b0;
      end else begin
        valid_d = valid_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sdin_q     <= 1'b0;
      left_sh_q  <= '0;
      right_sh_q <= '0;
      left_q     <= '0;
      right_q    <= '0;
      valid_q    <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      sdin_q     <= sdin;
      left_sh_q  <= left_sh_d;
      right_sh_q <= right_sh_d;
      left_q     <= left_d;
      right_q    <= right_d;
      valid_q    <= valid_d;
      ovr_q      <= ovr_d;
    end
  end

  assign left_data    = left_q;
  assign right_data   = right_q;
  assign sample_valid = valid_q;
  assign overrun      = ovr_q;

endmodule

// File: doc/i2s_rx.md
I2S_RX -- requirements
Module: i2s_rx

Interface
REQ-001 SHALL have parameter DATA_W, default 24: sample width in bits, MSB first.
REQ-002 SHALL have parameter SLOT_W, default 32: sclk periods per channel slot.
REQ-003 SHALL have parameter SCLK_DIV, default 8: clk cycles per sclk half-period.
REQ-004 SHALL have port clk, input, 1: single system clock, nominally 25 MHz; rising edge only.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port mclk, output, 1: ADC master clock, clk/2.
REQ-007 SHALL have port sclk, output, 1: bit clock, clk/(2*SCLK_DIV).
REQ-008 SHALL have port lrck, output, 1: word select; 0 = left slot, 1 = right slot.
REQ-009 SHALL have port sdin, input, 1: serial data from the ADC, asynchronous to clk.
REQ-010 SHALL have port left_data, output, DATA_W: last published left sample, two's complement.
REQ-011 SHALL have port right_data, output, DATA_W: last published right sample, two's complement.
REQ-012 SHALL have port sample_valid, output, 1: a published stereo pair is pending.
REQ-013 SHALL have port sample_ready, input, 1: consumer accepts the pending pair.
REQ-014 SHALL have port overrun, output, 1: one-cycle pulse when a completed frame is dropped.

Function
REQ-015 SHALL toggle mclk on every clk edge.
REQ-016 SHALL count div_cnt 0..2*SCLK_DIV-1 with wrap; sclk = 1 while div_cnt >= SCLK_DIV.
REQ-017 SHALL count bit_cnt 0..2*SLOT_W-1, advancing on div_cnt wrap (sclk falling edge), wrapping to 0.
REQ-018 SHALL drive lrck = 1 when bit_cnt >= SLOT_W; lrck changes only on the sclk falling edge.
REQ-019 SHALL register sdin into sdin_q every clk and capture sdin_q when div_cnt == 3*SCLK_DIV/2 (mid sclk-high).
REQ-020 SHALL treat slot bit 0 as the I2S delay bit and capture slot bits 1..DATA_W, MSB first; slot bits DATA_W+1..SLOT_W-1 are ignored.
REQ-021 SHALL use FSM states SYNC and RUN; reset enters SYNC; SYNC->RUN at end of the first full frame (bit_cnt == 2*SLOT_W-1, div_cnt wrap); data in SYNC is discarded.
REQ-022 SHALL define frame end as bit_cnt == 2*SLOT_W-1 with div_cnt == 2*SCLK_DIV-1; in RUN at frame end the left and right shift registers become a completed pair.
REQ-023 SHALL, at frame end with sample_valid == 0 or sample_ready == 1 in the same cycle, load left_data/right_data and set sample_valid on the next clk.
REQ-024 SHALL, at frame end with sample_valid == 1 and sample_ready == 0, keep the old outputs, drop the new pair, and pulse overrun for one cycle.
REQ-025 SHALL clear sample_valid on a cycle with sample_ready == 1 unless REQ-023 reloads it in that same cycle; a simultaneous accept and frame end yields the new pair with valid remaining high.
REQ-026 SHALL hold left_data/right_data stable while sample_valid == 1.

Reset
REQ-027 SHALL, on reset == 1 at a clk edge, clear div_cnt, bit_cnt, shift registers, left_data, right_data, sample_valid, overrun, mclk, sclk and lrck to 0 and enter SYNC.
REQ-028 SHALL apply reset mid-frame identically; no partial pair is ever published.

Structure
REQ-029 SHALL take DATA_W, SLOT_W and SCLK_DIV defaults from shared package i2s_pkg, also used by the I2S transmitter.
REQ-030 SHALL place mclk/sclk/lrck generation and the div_cnt/bit_cnt counters in sub-module i2s_clk_gen, exporting sample-strobe and frame-end strobes.

Verification
REQ-031 SHALL check, after reset release: mclk period 2 clk; sclk period 16 clk; lrck period 1024 clk, low for the first 512.
REQ-032 SHALL drive an ADC model with left 24'h800001 and right 24'h7FFFFE; after the SYNC frame, sample_valid rises 1 clk after the second frame end with exactly these values.
REQ-033 SHALL hold sample_ready = 0 across two frame ends and check one overrun pulse at the second frame end, with the first pair retained.
REQ-034 SHALL assert sample_ready exactly at a frame end with valid pending and check the new pair loads, valid stays 1, and no overrun occurs.
REQ-035 SHALL assert reset at bit_cnt = 40 and check all outputs are 0 next clk, and the first valid appears only after one full discarded frame.
REQ-036 SHALL drive 1s in the delay bit and bits 25..31 with data 24'h000000 and check the captured values are 24'h000000.
